// File: rtl/p_mul_pkg.sv
// rtl/p_mul_pkg.sv - shared types, pack-width indices and lane-width helper for p_mul_gen
package p_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit k of the one-hot pack-width field selects lanes of XLEN>>k bits.
    localparam int PW_IDX_FULL      = 0;
    localparam int PW_IDX_HALF      = 1;
    localparam int PW_IDX_QUARTER   = 2;
    localparam int PW_IDX_EIGHTH    = 3;
    localparam int PW_IDX_SIXTEENTH = 4;
    localparam int PW_IDX_32ND      = 5;

    localparam int PW_MAX_BITS = 8;

    function automatic int lane_width(input logic [PW_MAX_BITS-1:0] pw, input int xlen);
        int w;
        w = 0;
        for (int k = 0; k < PW_MAX_BITS; k++) begin
            if (pw[k]) begin
                w = xlen >> k;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/p_addsub.sv
// rtl/p_addsub.sv - packed-lane adder/subtractor, carries never cross a lane boundary
module p_addsub #(
    parameter int W   = 64,
    parameter int PWN = 5
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           sub,
    input  logic [PWN-1:0] pw,
    output logic [W-1:0]   sum
);

    logic [W-1:0] lane_start;
    logic [W-1:0] bx;

    // pw bit k selects lanes of W>>k bits within this vector
    always_comb begin
        lane_start = '0;
        for (int k = 0; k < PWN; k++) begin
            for (int p = 0; p < W; p++) begin
                if (pw[k] && ((p % (W >> k)) == 0)) begin
                    lane_start[p] = 1'b1;
                end
            end
        end
    end

    assign bx = b ^ {W{sub}};

    always_comb begin
        logic carry;
        carry = sub;
        sum   = '0;
        for (int p = 0; p < W; p++) begin
            if (lane_start[p]) begin
                carry = sub;
            end
            sum[p] = a[p] ^ bx[p] ^ carry;
            carry  = (a[p] & bx[p]) | (carry & (a[p] ^ bx[p]));
        end
    end

endmodule

// File: rtl/p_mul_step.sv
// rtl/p_mul_step.sv - one BPC-bit packed shift-add (or shift-xor) multiply step
module p_mul_step
    import p_mul_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BPC  = 1,
    parameter int PWN  = 5
) (
    input  logic [2*XLEN-1:0] psum,
    input  logic [2*XLEN-1:0] mcand,
    input  logic [XLEN-1:0]   mplier,
    input  logic [PWN-1:0]    pw,
    input  logic              clmul,
    output logic [2*XLEN-1:0] psum_next,
    output logic [2*XLEN-1:0] mcand_next,
    output logic [XLEN-1:0]   mplier_next
);

    localparam int WW = 2 * XLEN;

    logic [WW-1:0]   ps_s [BPC+1];
    logic [WW-1:0]   mc_s [BPC+1];
    logic [XLEN-1:0] mp_s [BPC+1];

    assign ps_s[0] = psum;
    assign mc_s[0] = mcand;
    assign mp_s[0] = mplier;

    // Lane i of the multiplicand lives in the 2L-bit wide slot i, so shifting the whole
    // vector left never pushes bits into a neighbouring slot within L steps.
    for (genvar b = 0; b < BPC; b++) begin : g_stage
        logic [WW-1:0] wmask;
        logic [WW-1:0] addend;
        logic [WW-1:0] sum;

        always_comb begin
            wmask = '0;
            for (int k = 0; k < PWN; k++) begin
                for (int q = 0; q < WW; q++) begin
                    if (pw[k] && mp_s[b][(q / (2 * (XLEN >> k))) * (XLEN >> k)]) begin
                        wmask[q] = 1'b1;
                    end
                end
            end
        end

        assign addend = mc_s[b] & wmask;

        p_addsub #(
            .W   (WW),
            .PWN (PWN)
        ) u_add (
            .a   (ps_s[b]),
            .b   (addend),
            .sub (1'b0),
            .pw  (pw),
            .sum (sum)
        );

        assign ps_s[b+1] = clmul ? (ps_s[b] ^ addend) : sum;
        assign mc_s[b+1] = mc_s[b] << 1;
        assign mp_s[b+1] = mp_s[b] >> 1;
    end

    assign psum_next   = ps_s[BPC];
    assign mcand_next  = mc_s[BPC];
    assign mplier_next = mp_s[BPC];

endmodule

// File: rtl/p_mul_gen.sv
// rtl/p_mul_gen.sv - iterative packed-lane multiplier (low/high/carry-less) with req/rsp handshake
module p_mul_gen
    import p_mul_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BPC  = 1,
    localparam int PWN = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_mul_l,
    input  logic            req_mul_h,
    input  logic            req_clmul,
    input  logic [PWN-1:0]  req_pw,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_err
);

    localparam int WW = 2 * XLEN;

    state_t          state;
    state_t          state_nxt;
    logic [WW-1:0]   psum_q;
    logic [WW-1:0]   mcand_q;
    logic [WW-1:0]   psum_nxt;
    logic [WW-1:0]   mcand_nxt;
    logic [WW-1:0]   mcand_init;
    logic [XLEN-1:0] mplier_q;
    logic [XLEN-1:0] mplier_nxt;
    logic [XLEN-1:0] result;
    logic [PWN-1:0]  pw_q;
    logic [PWN-1:0]  cnt_q;
    logic            mul_h_q;
    logic            clmul_q;
    logic            err_q;
    logic            accept;
    logic            legal;
    logic            last_step;

    assign accept    = req_valid && (state == ST_IDLE) && !flush;
    assign legal     = (req_pw != '0) && ((req_pw & (req_pw - 1'b1)) == '0)
                       && (req_mul_l != req_mul_h);
    assign last_step = (int'(cnt_q) == (lane_width(PW_MAX_BITS'(pw_q), XLEN) / BPC) - 1);

    // Spread each rs1 lane into the low half of its 2L-bit product slot.
    always_comb begin
        mcand_init = '0;
        for (int k = 0; k < PWN; k++) begin
            for (int q = 0; q < WW; q++) begin
                if (req_pw[k] && ((q % (2 * (XLEN >> k))) < (XLEN >> k))) begin
                    mcand_init[q] = req_rs1[(q / (2 * (XLEN >> k))) * (XLEN >> k)
                                            + (q % (XLEN >> k))];
                end
            end
        end
    end

    p_mul_step #(
        .XLEN (XLEN),
        .BPC  (BPC),
        .PWN  (PWN)
    ) u_step (
        .psum        (psum_q),
        .mcand       (mcand_q),
        .mplier      (mplier_q),
        .pw          (pw_q),
        .clmul       (clmul_q),
        .psum_next   (psum_nxt),
        .mcand_next  (mcand_nxt),
        .mplier_next (mplier_nxt)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    state_nxt = legal ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (last_step) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            psum_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            pw_q     <= '0;
            cnt_q    <= '0;
            mul_h_q  <= 1'b0;
            clmul_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (accept) begin
            psum_q   <= '0;
            mcand_q  <= mcand_init;
            mplier_q <= req_rs2;
            pw_q     <= req_pw;
            cnt_q    <= '0;
            mul_h_q  <= req_mul_h;
            clmul_q  <= req_clmul;
            err_q    <= !legal;
        end else if ((state == ST_RUN) && !flush) begin
            psum_q   <= psum_nxt;
            mcand_q  <= mcand_nxt;
            mplier_q <= mplier_nxt;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

    // Gather low or high half of every 2L-bit product slot back into packed lanes.
    always_comb begin
        result = '0;
        for (int k = 0; k < PWN; k++) begin
            for (int p = 0; p < XLEN; p++) begin
                if (pw_q[k]) begin
                    if (mul_h_q) begin
                        result[p] = psum_q[2 * (XLEN >> k) * (p / (XLEN >> k))
                                           + (p % (XLEN >> k)) + (XLEN >> k)];
                    end else begin
                        result[p] = psum_q[2 * (XLEN >> k) * (p / (XLEN >> k))
                                           + (p % (XLEN >> k))];
                    end
                end
            end
        end
    end

    assign rsp_err    = rsp_valid && err_q;
    assign rsp_result = (rsp_valid && !err_q) ? result : '0;

endmodule
